// File: rtl/s_axi_regfile_v2.sv
// Single-beat AXI4 slave register file with 1-deep AW/W buffers, ID echo and an XOR checksum word.
// Optional S_AXI_REGFILE_V2_CYCLE_CNT_EN maps a free-running cycle counter at index NUM_REGS+1.
module s_axi_regfile_v2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_WIDTH-1:0]     wid_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]      w_strb_q, w_strb_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d, rid_q, rid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] csum, rd_val;
  logic [1:0]            rd_resp;

  logic unused_inputs;
  assign unused_inputs = ^{wid_i, wlast_i};

`ifdef S_AXI_REGFILE_V2_CYCLE_CNT_EN
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 1'b1;
`endif

  assign awready_o = !aw_full_q;
  assign wready_o  = !w_full_q;
  assign arready_o = !rvalid_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign rvalid_o  = rvalid_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rvalid_q;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_REGS; i++) csum ^= regs_q[i];
  end

  // Read mux sees pre-edge register state, so a same-edge commit returns old data.
  always_comb begin
    ar_idx  = araddr_i >> AddrLsb;
    rd_val  = '0;
    rd_resp = RespSlvErr;
    if (ar_idx < ADDR_WIDTH'(NUM_REGS)) begin
      rd_resp = RespOkay;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ar_idx == ADDR_WIDTH'(i)) rd_val = regs_q[i];
      end
    end else if (ar_idx == ADDR_WIDTH'(NUM_REGS)) begin
      rd_resp = RespOkay;
      rd_val  = csum;
`ifdef S_AXI_REGFILE_V2_CYCLE_CNT_EN
    end else if (ar_idx == ADDR_WIDTH'(NUM_REGS + 1)) begin
      rd_resp = RespOkay;
      rd_val  = cnt_q;
`endif
    end
  end

  always_comb begin
    aw_hs  = awvalid_i && !aw_full_q;
    w_hs   = wvalid_i && !w_full_q;
    ar_hs  = arvalid_i && !rvalid_q;
    commit = aw_full_q && w_full_q && (!bvalid_q || bready_i);
    aw_idx = aw_addr_q >> AddrLsb;

    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    // Handshake and commit are mutually exclusive per buffer (full vs. empty).
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr_i;
      aw_id_d   = awid_i;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bid_d     = aw_id_q;
      bresp_d   = (aw_idx < ADDR_WIDTH'(NUM_REGS)) ? RespOkay : RespSlvErr;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx == ADDR_WIDTH'(i)) begin
          for (int b = 0; b < StrbW; b++) begin
            if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end else if (bready_i) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rid_d    = arid_i;
      rdata_d  = rd_val;
      rresp_d  = rd_resp;
    end else if (rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef S_AXI_REGFILE_V2_CYCLE_CNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef S_AXI_REGFILE_V2_CYCLE_CNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_s_axi_regfile_v2.sv
// Directed bench for s_axi_regfile_v2: a vector table of single writes/reads plus hand-timed
// sequences for write timing, B backpressure, read/commit collision and mid-transaction reset.
module tb_s_axi_regfile_v2;

  logic        clk;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_tests = 0;
  int n_fail  = 0;

  s_axi_regfile_v2 dut (
    .clk      (clk),
    .areset   (areset),
    .awid_i   (awid),
    .awaddr_i (awaddr),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .wid_i    (wid),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .wlast_i  (wlast),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .bid_o    (bid),
    .bresp_o  (bresp),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .arid_i   (arid),
    .araddr_i (araddr),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .rid_o    (rid),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .rlast_o  (rlast),
    .rvalid_o (rvalid),
    .rready_i (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic [1:0]  exp_resp;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"}, wready, 1);
    check({tag, "_arready"}, arready, 1);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_bid"}, bid, 0);
    check({tag, "_rid"}, rid, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rlast"}, rlast, 0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] id, output logic [1:0] resp, output logic [3:0] rsp_id);
    bit aw_done, w_done, b_done, aw_go, w_go;
    resp = 2'b11;
    rsp_id = 4'hx;
    @(negedge clk);
    awaddr = addr; awid = id; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 0, 1);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      return;
    end
    b_done = 1'b0;
    for (int c = 0; c < 20 && !b_done; c++) begin
      if (bvalid) begin resp = bresp; rsp_id = bid; b_done = 1'b1; end
      @(negedge clk);
    end
    bready = 1'b0;
    if (!b_done) check("wr_b_timeout", 0, 1);
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [3:0] id, output logic [31:0] data,
                          output logic [1:0] resp, output logic [3:0] rsp_id, output logic last);
    bit got, go;
    data = 32'hx; resp = 2'b11; rsp_id = 4'hx; last = 1'bx;
    @(negedge clk);
    araddr = addr; arid = id; arvalid = 1'b1; rready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      go = arready;
      @(negedge clk);
      if (go) begin arvalid = 1'b0; got = 1'b1; end
    end
    if (!got) begin
      check("rd_ar_timeout", 0, 1);
      arvalid = 1'b0;
      return;
    end
    check("rd_rvalid_after_ar", rvalid, 1);
    data = rdata; resp = rresp; rsp_id = rid; last = rlast;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;
  logic        r_last;
  logic [31:0] c1, c2;

  initial begin
    vecs[0]  = '{1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h5, 4'd1,  2'b00, 0, 32'h0};
    vecs[1]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 4'd2,  2'b00, 1, 32'h00FF_00FF};
    vecs[2]  = '{1, 32'h0000_0020, 32'h1234_5678, 4'hF, 4'd6,  2'b10, 0, 32'h0};
    vecs[3]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 4'd7,  2'b00, 1, 32'h00FF_00FF};
    vecs[4]  = '{0, 32'h0000_0040, 32'h0,         4'h0, 4'd8,  2'b10, 1, 32'h0};
    vecs[5]  = '{1, 32'h0000_001C, 32'hA5A5_A5A5, 4'hA, 4'd9,  2'b00, 0, 32'h0};
    vecs[6]  = '{0, 32'h0000_001C, 32'h0,         4'h0, 4'd10, 2'b00, 1, 32'hA500_A500};
    vecs[7]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 4'd11, 2'b00, 1, 32'hA5FF_A5FF};
    vecs[8]  = '{1, 32'h0000_0024, 32'h0000_0001, 4'hF, 4'd11, 2'b10, 0, 32'h0};
`ifdef S_AXI_REGFILE_V2_CYCLE_CNT_EN
    vecs[9]  = '{0, 32'h0000_0024, 32'h0,         4'h0, 4'd12, 2'b00, 0, 32'h0};
`else
    vecs[9]  = '{0, 32'h0000_0024, 32'h0,         4'h0, 4'd12, 2'b10, 1, 32'h0};
`endif
    vecs[10] = '{1, 32'h0000_0004, 32'h1122_3344, 4'h3, 4'd12, 2'b00, 0, 32'h0};
    vecs[11] = '{0, 32'h0000_0004, 32'h0,         4'h0, 4'd13, 2'b00, 1, 32'h0000_3344};
    vecs[12] = '{1, 32'h0000_0001, 32'hFFFF_FFFF, 4'h8, 4'd13, 2'b00, 0, 32'h0};
    vecs[13] = '{0, 32'h0000_0000, 32'h0,         4'h0, 4'd14, 2'b00, 1, 32'hFFFF_00FF};
    vecs[14] = '{0, 32'h8000_0000, 32'h0,         4'h0, 4'd15, 2'b10, 1, 32'h0};
    vecs[15] = '{0, 32'h0000_001F, 32'h0,         4'h0, 4'd0,  2'b00, 1, 32'hA500_A500};
    vecs[16] = '{0, 32'h0000_0020, 32'h0,         4'h0, 4'd1,  2'b00, 1, 32'h5AFF_96BB};

    awid = '0; awaddr = '0; awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b1;
    wvalid = 1'b0; bready = 1'b0; arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    areset = 1'b1;
    #2 areset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    areset = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      if (vecs[i].is_wr) begin
        write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, r_resp, r_id);
        check($sformatf("vec%0d_bresp", i), r_resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_bid", i), r_id, vecs[i].id);
      end else begin
        read_txn(vecs[i].addr, vecs[i].id, r_data, r_resp, r_id, r_last);
        check($sformatf("vec%0d_rresp", i), r_resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rid", i), r_id, vecs[i].id);
        check($sformatf("vec%0d_rlast", i), r_last, 1);
        if (vecs[i].chk_data) check($sformatf("vec%0d_rdata", i), r_data, vecs[i].exp_data);
      end
    end

    // AW first, W two cycles later; B must rise one edge after the W handshake.
    @(negedge clk);
    awaddr = 32'h08; awid = 4'd3; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("t1_awready_full", awready, 0);
    @(negedge clk);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("t1_no_early_bvalid", bvalid, 0);
    bready = 1'b1;
    @(negedge clk);
    check("t1_bvalid", bvalid, 1);
    check("t1_bid", bid, 3);
    check("t1_bresp", bresp, 0);
    @(negedge clk);
    bready = 1'b0;
    check("t1_bvalid_cleared", bvalid, 0);
    read_txn(32'h08, 4'd5, r_data, r_resp, r_id, r_last);
    check("t1_rdata", r_data, 32'hDEAD_BEEF);
    check("t1_rid", r_id, 5);
    check("t1_rresp", r_resp, 0);
    check("t1_rlast", r_last, 1);

    // B backpressure: second pair is buffered and commits only at the B handshake edge.
    @(negedge clk);
    awaddr = 32'h0C; awid = 4'd1; awvalid = 1'b1;
    wdata = 32'h1111_1111; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("t4_bvalid_first", bvalid, 1);
    check("t4_bid_first", bid, 1);
    awaddr = 32'h10; awid = 4'd2; awvalid = 1'b1;
    wdata = 32'h2222_2222; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_awready_low%0d", k), awready, 0);
      check($sformatf("t4_wready_low%0d", k), wready, 0);
      check($sformatf("t4_bid_held%0d", k), {bvalid, bid}, {1'b1, 4'd1});
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    check("t4_bvalid_second", bvalid, 1);
    check("t4_bid_second", bid, 2);
    check("t4_awready_back", awready, 1);
    @(negedge clk);
    bready = 1'b0;
    check("t4_bvalid_done", bvalid, 0);
    read_txn(32'h0C, 4'd4, r_data, r_resp, r_id, r_last);
    check("t4_reg3", r_data, 32'h1111_1111);
    read_txn(32'h10, 4'd4, r_data, r_resp, r_id, r_last);
    check("t4_reg4", r_data, 32'h2222_2222);

    // AR handshake on the same edge as a commit to the same register returns old data.
    @(negedge clk);
    awaddr = 32'h04; awid = 4'd4; awvalid = 1'b1;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h04; arid = 4'd3; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("t5_bvalid", bvalid, 1);
    check("t5_rvalid", rvalid, 1);
    check("t5_old_data", rdata, 32'h0000_3344);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    read_txn(32'h04, 4'd6, r_data, r_resp, r_id, r_last);
    check("t5_new_data", r_data, 32'hCAFE_F00D);

    // Reset with a buffered AW and a pending R beat.
    @(negedge clk);
    awaddr = 32'h08; awid = 4'd5; awvalid = 1'b1;
    araddr = 32'h08; arid = 4'd9; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    check("t6_aw_full", awready, 0);
    check("t6_rvalid_pending", rvalid, 1);
    areset = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    @(negedge clk);
    areset = 1'b1;
    write_txn(32'h14, 32'h55AA_55AA, 4'hF, 4'd6, r_resp, r_id);
    check("t6_bresp", r_resp, 0);
    check("t6_bid", r_id, 6);
    read_txn(32'h14, 4'd7, r_data, r_resp, r_id, r_last);
    check("t6_reg5", r_data, 32'h55AA_55AA);
    read_txn(32'h08, 4'd7, r_data, r_resp, r_id, r_last);
    check("t6_reg2_cleared", r_data, 0);

`ifdef S_AXI_REGFILE_V2_CYCLE_CNT_EN
    // Two counter reads whose AR handshakes are 7 edges apart.
    @(negedge clk);
    araddr = 32'h24; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    c1 = rdata;
    check("cnt_rresp1", rresp, 0);
    repeat (6) @(negedge clk);
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    c2 = rdata;
    check("cnt_delta", c2 - c1, 7);
    @(negedge clk);
    rready = 1'b0;
`else
    c1 = '0;
    c2 = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s_axi_regfile_v2.md
Name: s_axi_regfile_v2

Overview:
Parametrised AXI4 slave register file, the successor to the fixed 8 x 32-bit register block. It adds:
- configurable register count, data width and ID width;
- independent 1-deep AW and W holding buffers;
- ID echo on the B and R channels;
- RRESP/BRESP error signalling;
- a read-only XOR checksum register located directly after the register array.

It sits on the AXI interconnect as a control/status target. Transactions are single-beat only.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8 and at least 16.
- ADDR_WIDTH, 32, address bus width in bits.
- ID_WIDTH, 4, width of the AWID/WID/ARID/RID/BID fields.
- NUM_REGS, 8, number of read/write registers; range 1..256.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous active-low reset.
- awid_i  in  ID_WIDTH  write address ID.
- awaddr_i  in  ADDR_WIDTH  write byte address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wid_i  in  ID_WIDTH  write data ID; ignored.
- wdata_i  in  DATA_WIDTH  write data.
- wstrb_i  in  DATA_WIDTH/8  byte strobes.
- wlast_i  in  1  last beat; ignored, every beat is treated as last.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- bid_o  out  ID_WIDTH  response ID, equal to the captured awid.
- bresp_o  out  2  write response.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.
- arid_i  in  ID_WIDTH  read address ID.
- araddr_i  in  ADDR_WIDTH  read byte address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rid_o  out  ID_WIDTH  read ID, equal to the captured arid.
- rdata_o  out  DATA_WIDTH  read data.
- rresp_o  out  2  read response.
- rlast_o  out  1  last beat; driven 1 whenever rvalid_o is 1.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data ready.

Behaviour:
- Reset values: all registers 0, all buffers empty, awready_o=1, wready_o=1, arready_o=1, bvalid_o=0, rvalid_o=0, bid_o=0, rid_o=0, bresp_o=0, rresp_o=0, rdata_o=0, rlast_o=0. Reset asserted mid-transaction discards every pending transaction immediately; no response is issued for it.
- Word index: idx = addr >> log2(DATA_WIDTH/8). Upper bits are not masked: any idx > NUM_REGS is out of range.
- Address map:
  - idx < NUM_REGS: read/write register.
  - idx == NUM_REGS: checksum, the XOR of all registers; read-only.
  - all other idx: unmapped.
- AW buffer:
  - awready_o = !aw_full.
  - An AW handshake captures awaddr and awid and sets aw_full.
- W buffer:
  - wready_o = !w_full.
  - A W handshake captures wdata and wstrb and sets w_full.
  - AW and W may arrive in either order or in the same cycle.
- Write commit:
  - Occurs at an edge where aw_full && w_full && (!bvalid_o || bready_i).
  - On commit: bytes enabled by wstrb are written to the register; both buffers are cleared; bvalid_o=1; bid_o = captured awid.
  - bresp_o = 2'b00 (OKAY) for idx < NUM_REGS.
  - bresp_o = 2'b10 (SLVERR) for idx >= NUM_REGS; no register changes.
- Write timing:
  - Commit occurs at the edge after the later of the two handshakes.
  - bvalid_o is high from that edge and holds until the B handshake.
  - A new AW/W may be buffered while bvalid_o is high.
- Read:
  - arready_o = !rvalid_o.
  - On an AR handshake, the next edge sets rvalid_o=1, rid_o=arid, rlast_o=1, and rdata_o from the register/checksum value before any same-edge write commit (old data).
  - rresp_o = OKAY for idx <= NUM_REGS.
  - rresp_o = SLVERR with rdata_o=0 for unmapped idx.
  - Outputs hold until the R handshake, after which rvalid_o=0 and arready_o=1.
  - Maximum read throughput is one read per 2 cycles.
- Read and write channels are fully independent; there is no ordering between them.

Optional Feature:
Macro S_AXI_REGFILE_V2_CYCLE_CNT_EN.
- Defined:
  - idx NUM_REGS+1 maps to a read-only free-running DATA_WIDTH cycle counter.
  - The counter is 0 at reset, increments every clk, and wraps at all-ones back to 0.
  - Reads of this index return OKAY with the counter value sampled at the AR handshake edge.
  - Writes to this index return SLVERR and do not change the counter.
- Not defined: idx NUM_REGS+1 is unmapped (SLVERR, rdata 0) and no counter logic exists.

Test Plan:
1. AW awaddr=0x08, awid=3 one cycle, then W wdata=0xDEADBEEF, wstrb=0xF two cycles later → bvalid with bid=3, bresp=00; read 0x08 with arid=5 → rdata=0xDEADBEEF, rid=5, rresp=00, rlast=1.
2. Same-cycle AW 0x00 and W 0xFFFFFFFF with wstrb=0x5 → reg0=0x00FF00FF; read 0x20 (checksum, all other registers 0) → 0x00FF00FF.
3. Write to 0x20 (checksum) → bresp=10 and checksum unchanged; read 0x40 → rresp=10, rdata=0.
4. Hold bready_i=0 for 5 cycles after the first write while a second AW/W pair arrives → second pair is buffered and awready/wready drop; commit occurs only at the B handshake edge; second bid is correct.
5. AR to reg1 issued in the same cycle as a commit to reg1 → rdata returns the old value; a subsequent read returns the new value.
6. Assert areset with aw_full=1 and rvalid_o=1 → all outputs return to reset values; the next write completes normally. With the macro defined, two reads of 0x24 N cycles apart differ by N.
